// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares one single-ported, variable-latency memory bus between the core's
// instruction-fetch port (i_*) and data port (d_*). One transaction is in
// flight at a time.
//
// Arbitration:
//   - Data wins, except when i_req is pending and data has already taken
//     STARVE_MAX consecutive grants while instruction was waiting.
//   - A bus transaction that sees no m_ack for TIMEOUT cycles is aborted.
//     The requester then gets its ack, rdata=0 and a one-cycle err pulse.
//
// FSM: IDLE -> BUS -> RESP -> IDLE
//   IDLE : arbitrate and register the winner's request onto m_*
//   BUS  : m_* held, wait for m_ack or timeout
//   RESP : winner's ack (and err on abort) high for this single cycle
//
// Parameters:
//   STARVE_MAX  consecutive data grants tolerated while i_req waits (def 4)
//   TIMEOUT     BUS cycles without m_ack before abort, 1..255     (def 255)
//
// Ports:
//   clk, rst                     rising-edge clock, async active-high reset
//   i_req/i_addr                 instruction read request (held until i_ack)
//   i_rdata/i_ack                instruction read data, completion pulse
//   d_req/d_wen/d_size/d_addr/d_wdata   data request (held until d_ack)
//   d_rdata/d_ack                data read data, completion pulse
//   m_req/m_wen/m_size/m_addr/m_wdata   memory bus request
//   m_rdata/m_ack                memory bus response
//   err                          timeout pulse, coincident with the ack
//
// Optional build macro ARB_PERF_CNT_EN adds:
//   conflict_cnt  grants made while both sides were requesting
//   stall_cnt     cycles spent in BUS
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    input  logic        d_req,
    input  logic        d_wen,
    input  logic [2:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        m_req,
    output logic        m_wen,
    output logic [2:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ack,
    output logic        err
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0] conflict_cnt,
    output logic [31:0] stall_cnt
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUS  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam int              STARVE_W     = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);
    // timeoutCnt counts BUS cycles already spent without m_ack, so the
    // abort fires during the TIMEOUT-th BUS cycle.
    localparam logic [7:0]      TIMEOUT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]          state;
    logic [STARVE_W-1:0] starveCnt;
    logic [7:0]          timeoutCnt;
    logic                grantI;     // 1: transaction in flight belongs to i side

    logic        pickI;
    logic        busDone;
    logic [31:0] respData;

    // Instruction wins when data is idle or data has starved it long enough.
    assign pickI    = i_req && (!d_req || (starveCnt == STARVE_LIM));
    // A same-cycle m_ack on the last allowed cycle is a success.
    assign busDone  = m_ack || (timeoutCnt == TIMEOUT_LAST);
    assign respData = m_ack ? m_rdata : 32'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            starveCnt  <= '0;
            timeoutCnt <= '0;
            grantI     <= 1'b0;
            m_req      <= 1'b0;
            m_wen      <= 1'b0;
            m_size     <= 3'd0;
            m_addr     <= 32'd0;
            m_wdata    <= 32'd0;
            i_rdata    <= 32'd0;
            d_rdata    <= 32'd0;
            i_ack      <= 1'b0;
            d_ack      <= 1'b0;
            err        <= 1'b0;
        end else begin
            // Completion strobes are single-cycle by construction.
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            err   <= 1'b0;

            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        state      <= BUS;
                        m_req      <= 1'b1;
                        timeoutCnt <= '0;
                        grantI     <= pickI;
                        if (pickI) begin
                            m_wen     <= 1'b0;
                            m_size    <= 3'b010;
                            m_addr    <= i_addr;
                            m_wdata   <= 32'd0;
                            starveCnt <= '0;
                        end else begin
                            m_wen   <= d_wen;
                            m_size  <= d_size;
                            m_addr  <= d_addr;
                            m_wdata <= d_wdata;
                            if (i_req && (starveCnt != STARVE_LIM)) begin
                                starveCnt <= starveCnt + STARVE_W'(1);
                            end
                        end
                    end
                end

                BUS: begin
                    if (busDone) begin
                        state <= RESP;
                        m_req <= 1'b0;
                        err   <= !m_ack;
                        if (grantI) begin
                            i_rdata <= respData;
                            i_ack   <= 1'b1;
                        end else begin
                            d_rdata <= respData;
                            d_ack   <= 1'b1;
                        end
                    end else begin
                        timeoutCnt <= timeoutCnt + 8'd1;
                    end
                end

                RESP: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt <= 32'd0;
            stall_cnt    <= 32'd0;
        end else begin
            // Every IDLE cycle with both requests high produces a grant.
            if ((state == IDLE) && i_req && d_req) begin
                conflict_cnt <= conflict_cnt + 32'd1;
            end
            if (state == BUS) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Scoreboard bench for mem_bus_arbiter (STARVE_MAX=4, TIMEOUT=8).
// Stimulus pushes the expected bus request and the expected completion into
// two queues; a monitor pops and compares whenever m_req rises or an
// ack/err appears. A memory responder acks m_req after a programmable
// number of BUS cycles.
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    typedef struct packed {
        logic        wen;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_t;

    typedef struct packed {
        logic        isD;
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        d_req;
    logic        d_wen;
    logic [2:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        m_req;
    logic        m_wen;
    logic [2:0]  m_size;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ack;
    logic        err;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] conflict_cnt;
    logic [31:0] stall_cnt;
`endif

    mem_bus_arbiter #(.STARVE_MAX(4), .TIMEOUT(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_rdata (i_rdata),
        .i_ack   (i_ack),
        .d_req   (d_req),
        .d_wen   (d_wen),
        .d_size  (d_size),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_rdata (d_rdata),
        .d_ack   (d_ack),
        .m_req   (m_req),
        .m_wen   (m_wen),
        .m_size  (m_size),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .m_ack   (m_ack),
        .err     (err)
`ifdef ARB_PERF_CNT_EN
        ,
        .conflict_cnt (conflict_cnt),
        .stall_cnt    (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nCompared = 0;
    int nMismatch = 0;

    bus_t  busQ[$];
    resp_t respQ[$];

    task automatic checkVal(input string name, input logic [71:0] act, input logic [71:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pushI(input logic [31:0] addr, input logic [31:0] rd);
        bus_t  b;
        resp_t r;
        b.wen = 1'b0; b.size = 3'b010; b.addr = addr; b.wdata = 32'd0;
        r.isD = 1'b0; r.err = 1'b0; r.rdata = rd;
        busQ.push_back(b);
        respQ.push_back(r);
    endtask

    task automatic pushD(input logic wen, input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rd, input logic e);
        bus_t  b;
        resp_t r;
        b.wen = wen; b.size = size; b.addr = addr; b.wdata = wdata;
        r.isD = 1'b1; r.err = e; r.rdata = rd;
        busQ.push_back(b);
        respQ.push_back(r);
    endtask

    // ---------------- memory responder ----------------
    int          busCyc   = 0;
    int          lat      = 1;
    bit          noAck    = 1'b0;
    bit          useXor   = 1'b0;
    bit          forceAck = 1'b0;
    logic [31:0] rdVal    = 32'd0;

    always @(negedge clk) begin
        if (m_req) busCyc++;
        else       busCyc = 0;
        if (forceAck) begin
            m_ack   = 1'b1;
            m_rdata = 32'h1111_2222;
        end else if (m_req && !noAck && (busCyc == lat)) begin
            m_ack   = 1'b1;
            m_rdata = useXor ? (m_addr ^ 32'hA5A5_0000) : rdVal;
        end else begin
            m_ack   = 1'b0;
            m_rdata = 32'hFFFF_FFFF;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic  prevMreq = 1'b0;
    bus_t  busExp;
    resp_t respExp;

    always @(posedge clk) begin
        #1;
        if (rst) begin
            prevMreq = 1'b0;
        end else begin
            if (m_req && !prevMreq) begin
                if (busQ.size() == 0) begin
                    nCompared++;
                    nMismatch++;
                    $display("FAIL bus_unexpected: got addr %h expected no request", m_addr);
                end else begin
                    busExp = busQ.pop_front();
                    checkVal("bus_req", 72'({m_wen, m_size, m_addr, m_wdata}), 72'(busExp));
                end
            end
            prevMreq = m_req;
            if (i_ack || d_ack || err) begin
                if (respQ.size() == 0) begin
                    nCompared++;
                    nMismatch++;
                    $display("FAIL resp_unexpected: got i_ack=%b d_ack=%b err=%b expected none",
                             i_ack, d_ack, err);
                end else begin
                    respExp = respQ.pop_front();
                    checkVal("resp",
                             72'({d_ack, i_ack, err, (d_ack ? d_rdata : i_rdata)}),
                             72'({respExp.isD, !respExp.isD, respExp.err, respExp.rdata}));
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Waits (bounded) for an ack; counts clock edges and m_req-high samples.
    task automatic waitAck(input string name, input int expEdges, output int mreqCyc);
        int n = 0;
        mreqCyc = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (m_req) mreqCyc++;
        end while (!(i_ack || d_ack) && n < 60);
        checkVal(name, 72'(n), 72'(expEdges));
    endtask

    // Both sides held high; each side moves to its next request after its ack.
    task automatic runMixed(input int nD, input logic [31:0] dBase,
                            input logic [31:0] iA0, input logic [31:0] iA1, input int nI);
        int dk = 0;
        int ik = 0;
        int n  = 0;
        d_req = 1'b1; d_wen = 1'b0; d_size = 3'b001; d_wdata = 32'hCAFE_0000; d_addr = dBase;
        i_req = 1'b1; i_addr = iA0;
        while ((dk < nD || ik < nI) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
            if (d_ack) begin
                dk++;
                if (dk < nD) d_addr = dBase + 32'(16 * dk);
                else         d_req = 1'b0;
`ifdef ARB_PERF_CNT_EN
                if (dk == 3 && dBase == 32'h800) begin
                    checkVal("conflict_cnt", 72'(conflict_cnt), 72'(3));
                    checkVal("stall_cnt", 72'(stall_cnt), 72'(6));
                end
`endif
            end
            if (i_ack) begin
                ik++;
                if (ik < nI) i_addr = iA1;
                else         i_req = 1'b0;
            end
        end
        checkVal("mixed_acks_done", 72'({dk, ik}), 72'({nD, nI}));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- main stimulus ----------------
    initial begin
        int mc;
        rst = 1'b1;
        i_req = 1'b0; i_addr = 32'd0;
        d_req = 1'b0; d_wen = 1'b0; d_size = 3'd0; d_addr = 32'd0; d_wdata = 32'd0;
        m_ack = 1'b0; m_rdata = 32'd0;

        repeat (3) @(posedge clk);
        #1;
        checkVal("reset_ctrl", 72'({m_req, m_wen, m_size, i_ack, d_ack, err}), 72'(0));
        checkVal("reset_data", 72'({i_rdata, d_rdata}), 72'(0));
        checkVal("reset_addr", 72'({m_addr, m_wdata}), 72'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single instruction read, 1-cycle bus latency.
        lat = 1; useXor = 1'b0; rdVal = 32'hDEAD_BEEF;
        pushI(32'h40, 32'hDEAD_BEEF);
        i_req = 1'b1; i_addr = 32'h40;
        waitAck("i_read_latency", 2, mc);
        i_req = 1'b0;
        @(posedge clk);
        #1;

        // Data store, 3-cycle bus latency.
        lat = 3; rdVal = 32'h0000_5555;
        pushD(1'b1, 3'b010, 32'h100, 32'h1234, 32'h0000_5555, 1'b0);
        d_req = 1'b1; d_wen = 1'b1; d_size = 3'b010; d_addr = 32'h100; d_wdata = 32'h1234;
        waitAck("d_store_latency", 4, mc);
        d_req = 1'b0; d_wen = 1'b0;
        checkVal("i_rdata_hold", 72'(i_rdata), 72'(32'hDEAD_BEEF));
        @(posedge clk);
        #1;

        // Contention: four data grants, then instruction; starve count restarts.
        lat = 2; useXor = 1'b1;
        pushD(1'b0, 3'b001, 32'h200, 32'hCAFE_0000, 32'hA5A5_0200, 1'b0);
        pushD(1'b0, 3'b001, 32'h210, 32'hCAFE_0000, 32'hA5A5_0210, 1'b0);
        pushD(1'b0, 3'b001, 32'h220, 32'hCAFE_0000, 32'hA5A5_0220, 1'b0);
        pushD(1'b0, 3'b001, 32'h230, 32'hCAFE_0000, 32'hA5A5_0230, 1'b0);
        pushI(32'h80, 32'hA5A5_0080);
        pushD(1'b0, 3'b001, 32'h240, 32'hCAFE_0000, 32'hA5A5_0240, 1'b0);
        pushD(1'b0, 3'b001, 32'h250, 32'hCAFE_0000, 32'hA5A5_0250, 1'b0);
        pushD(1'b0, 3'b001, 32'h260, 32'hCAFE_0000, 32'hA5A5_0260, 1'b0);
        pushD(1'b0, 3'b001, 32'h270, 32'hCAFE_0000, 32'hA5A5_0270, 1'b0);
        pushI(32'h84, 32'hA5A5_0084);
        runMixed(8, 32'h200, 32'h80, 32'h84, 2);

        // Timeout: no m_ack ever; abort after 8 BUS cycles.
        noAck = 1'b1;
        pushD(1'b0, 3'b100, 32'h300, 32'hCAFE_0000, 32'd0, 1'b1);
        d_req = 1'b1; d_wen = 1'b0; d_size = 3'b100; d_addr = 32'h300; d_wdata = 32'hCAFE_0000;
        waitAck("timeout_latency", 9, mc);
        checkVal("timeout_mreq_cycles", 72'(mc), 72'(8));
        d_req = 1'b0;
        noAck = 1'b0;
        @(posedge clk);
        #1;
        checkVal("timeout_idle", 72'({m_req, i_ack, d_ack, err}), 72'(0));

        // Reset in the middle of a bus transaction.
        noAck = 1'b1;
        pushI(32'h500, 32'd0);
        void'(respQ.pop_back());   // aborted by reset, no completion expected
        i_req = 1'b1; i_addr = 32'h500;
        repeat (3) @(posedge clk);
        #1;
        checkVal("midbus_mreq", 72'(m_req), 72'(1));
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkVal("rst_async_ctrl", 72'({m_req, i_ack, d_ack, err}), 72'(0));
        checkVal("rst_async_data", 72'({i_rdata, d_rdata}), 72'(0));
        i_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        noAck = 1'b0;

        // Stray m_ack while idle must be ignored.
        @(negedge clk);
        #2;
        forceAck = 1'b1;
        @(negedge clk);
        #2;
        forceAck = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkVal("late_mack_ignored", 72'({m_req, i_ack, d_ack, err, i_rdata}), 72'(0));

        // Three simultaneous-request grants at bus latency 2, then instruction.
        lat = 2; useXor = 1'b1;
        pushD(1'b0, 3'b001, 32'h800, 32'hCAFE_0000, 32'hA5A5_0800, 1'b0);
        pushD(1'b0, 3'b001, 32'h810, 32'hCAFE_0000, 32'hA5A5_0810, 1'b0);
        pushD(1'b0, 3'b001, 32'h820, 32'hCAFE_0000, 32'hA5A5_0820, 1'b0);
        pushI(32'h700, 32'hA5A5_0700);
        runMixed(3, 32'h800, 32'h700, 32'h700, 1);

        // Plain instruction read after reset recovery.
        lat = 1; useXor = 1'b0; rdVal = 32'h600D_F00D;
        pushI(32'h600, 32'h600D_F00D);
        i_req = 1'b1; i_addr = 32'h600;
        waitAck("post_rst_i_latency", 2, mc);
        i_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkVal("queues_drained", 72'({busQ.size(), respQ.size()}), 72'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
